logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, registered successor to the basic two-input gate set. Applies one selectable
//  bitwise gate (AND/OR/XOR/NAND/NOR/XNOR/NOT-A) to WIDTH-bit operands and carries the
//  result through an elastic pipeline of STAGES registers with valid/ready flow control.
//  Provides a reduction flag and a handshake counter. Sits between operand producers and
//  any consumer of logic results.
// PARAMETERS
//  WIDTH   8  operand/result width in bits, >=1
//  STAGES  2  pipeline depth in registers, 1..4; this is the zero-stall latency
//  CNT_W   8  width of txn_cnt
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        operands and op valid
//  in_ready   out  1        unit accepts this cycle
//  a          in   WIDTH    operand A
//  b          in   WIDTH    operand B
//  op         in   3        gate select, see BEHAVIOUR
//  out_valid  out  1        y/y_any/op_err valid
//  out_ready  in   1        consumer accepts
//  y          out  WIDTH    result
//  y_any      out  1        |y of the same result
//  op_err     out  1        result came from a reserved op code
//  txn_cnt    out  CNT_W    count of output handshakes, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - op: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A (b ignored),
//    111 reserved -> y=0, y_any=0, op_err=1. op_err=0 for every defined code.
//  - Compute is combinational at the input; result, y_any and op_err are captured into
//    stage 0 on accept (in_valid & in_ready). Later stages only move data.
//  - Stage k holds valid bit v[k] plus payload. Stage k loads from k-1 (or from the input
//    for k=0) when it is empty or the stage after it (or the consumer, for the last stage)
//    takes its data in the same cycle. in_ready = stage-0 load condition; combinational
//    from out_ready and the valid bits only, never from in_valid.
//  - Latency: STAGES cycles from accept to out_valid when out_ready stays 1.
//    Throughput: 1 result per cycle.
//  - Backpressure: with out_ready=0 the pipe fills. At most STAGES results are held, then
//    in_ready=0. Results leave strictly in acceptance order; no loss, no duplication.
//  - Full pipe with out_ready=1 and in_valid=1: the last stage emits, every stage shifts,
//    a new item is accepted, all in the same cycle.
//  - Hold: while out_valid=1 and out_ready=0, y/y_any/op_err stay stable.
//  - Payload registers of empty stages may hold stale data; y is defined only when out_valid=1.
//  - txn_cnt increments by 1 on each cycle with out_valid & out_ready.
//    Wraps from 2^CNT_W-1 to 0.
//  - Reset (asynchronous, any time, including mid-transfer): all v[k]=0, out_valid=0,
//    y=0, y_any=0, op_err=0, txn_cnt=0. Items in flight are dropped. in_ready=1 from the
//    first clock after release.
// TESTING
//  1 Reset: rst_n=0 -> out_valid=0, y=0, txn_cnt=0, in_ready=1 after release.
//  2 Ops (WIDTH=8, STAGES=2, out_ready=1): a=F0, b=CC, op 0..6 -> y=C0,FC,3C,3F,03,C3,0F,
//    each 2 cycles after accept; back-to-back at 1/cycle; y_any=1.
//  3 Exhaustive (WIDTH=1, STAGES=1): all 4 (a,b) x 7 ops match the truth table;
//    op=111 -> y=0, op_err=1, y_any=0.
//  4 Backpressure (STAGES=2): out_ready=0, offer 3 items -> 2 accepted, in_ready=0.
//    out_ready=1 -> items emerge in order, third accepted in the same cycle the first leaves.
//  5 Random valid/ready toggling (1000 items) vs scoreboard -> no loss, dup or reorder;
//    txn_cnt=1000 mod 256 = 232.
//  6 Reset mid-stream with pipe full -> out_valid drops immediately without a clock edge;
//    txn_cnt=0; no stale item appears after release. With CNT_W=4, 16 handshakes -> txn_cnt=0.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Selectable bitwise gate feeding an elastic valid/ready register pipeline,
// with a reduction flag, reserved-op flag and output handshake counter.
module logic_unit_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_any,
  output logic             op_err,
  output logic [CNT_W-1:0] txn_cnt
);

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] any_q;
  logic [STAGES-1:0] err_q;
  logic [WIDTH-1:0]  y_q [STAGES];
  logic [CNT_W-1:0]  cnt_q;

  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_any;
  logic [STAGES-1:0] src_err;
  logic [WIDTH-1:0]  src_y [STAGES];

  logic [WIDTH-1:0]  res;
  logic              res_err;

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    unique case (op)
      3'b000:  res = a & b;
      3'b001:  res = a | b;
      3'b010:  res = a ^ b;
      3'b011:  res = ~(a & b);
      3'b100:  res = ~(a | b);
      3'b101:  res = ~(a ^ b);
      3'b110:  res = ~a;
      default: res_err = 1'b1;
    endcase
  end

  // A stage loads when empty or when its successor drains it this cycle.
  always_comb begin
    ld = '0;
    ld[STAGES-1] = !v_q[STAGES-1] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      ld[k] = !v_q[k] | ld[k+1];
    end
  end

  always_comb begin
    src_v[0]   = in_valid;
    src_any[0] = |res;
    src_err[0] = res_err;
    src_y[0]   = res;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k]   = v_q[k-1];
      src_any[k] = any_q[k-1];
      src_err[k] = err_q[k-1];
      src_y[k]   = y_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      any_q <= '0;
      err_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        y_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          v_q[k] <= src_v[k];
          if (src_v[k]) begin
            y_q[k]   <= src_y[k];
            any_q[k] <= src_any[k];
            err_q[k] <= src_err[k];
          end
        end
      end
      if (out_valid && out_ready) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = v_q[STAGES-1];
  assign y         = y_q[STAGES-1];
  assign y_any     = any_q[STAGES-1];
  assign op_err    = err_q[STAGES-1];
  assign txn_cnt   = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: table vectors, backpressure, random flow,
// async reset, plus a 1-bit single-stage instance with a 4-bit counter.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit, 2-stage, 8-bit counter
  logic       iv0 = 0, ir0, ordy0 = 1, ov0, any0, err0;
  logic [7:0] a0 = 0, b0 = 0, y0, cnt0;
  logic [2:0] op0 = 0;

  // 1-bit, 1-stage, 4-bit counter
  logic       iv1 = 0, ir1, ov1, any1, err1;
  logic       a1 = 0, b1 = 0, y1;
  logic [2:0] op1 = 0;
  logic [3:0] cnt1;

  logic_unit_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv0), .in_ready(ir0),
    .a(a0), .b(b0), .op(op0),
    .out_valid(ov0), .out_ready(ordy0),
    .y(y0), .y_any(any0), .op_err(err0),
    .txn_cnt(cnt0)
  );

  logic_unit_pipe #(.WIDTH(1), .STAGES(1), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .op(op1),
    .out_valid(ov1), .out_ready(1'b1),
    .y(y1), .y_any(any1), .op_err(err1),
    .txn_cnt(cnt1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] y;
    logic       any;
    logic       err;
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic       any;
    logic       err;
    int         acc;
  } exp_t;

  vec_t tbl [8];
  exp_t q0 [$];
  exp_t q1 [$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pops0 = 0;
  bit lat_chk = 0;
  bit hit0, hit1;
  logic [7:0] nx_y0;
  logic       nx_any0, nx_err0;
  logic [7:0] nx_y1;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask

  function automatic logic [7:0] gate(input logic [7:0] a,
                                      input logic [7:0] b,
                                      input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return 8'h00;
    endcase
  endfunction

  // Sample handshakes at negedge, then advance past the next posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    hit0 = iv0 && ir0;
    hit1 = iv1 && ir1;
    if (hit0) begin
      e.y = nx_y0; e.any = nx_any0; e.err = nx_err0; e.acc = cyc;
      q0.push_back(e);
    end
    if (ov0 && ordy0) begin
      pops0++;
      if (q0.size() == 0) chk("u0_unexpected_out", 1, 0);
      else begin
        e = q0.pop_front();
        chk("u0_y", y0, e.y);
        chk("u0_any", any0, e.any);
        chk("u0_err", err0, e.err);
        if (lat_chk) chk("u0_latency", cyc - e.acc, 2);
      end
    end
    if (hit1) begin
      e.y = nx_y1; e.any = nx_y1[0]; e.err = (op1 == 3'd7); e.acc = cyc;
      q1.push_back(e);
    end
    if (ov1) begin
      if (q1.size() == 0) chk("u1_unexpected_out", 1, 0);
      else begin
        e = q1.pop_front();
        chk("u1_y", y1, e.y[0]);
        chk("u1_any", any1, e.any);
        chk("u1_err", err1, e.err);
        chk("u1_latency", cyc - e.acc, 1);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive0(input vec_t v);
    a0 = v.a; b0 = v.b; op0 = v.op;
    nx_y0 = v.y; nx_any0 = v.any; nx_err0 = v.err;
  endtask

  task automatic drain(input int n);
    iv0 = 0; iv1 = 0; ordy0 = 1;
    for (int i = 0; i < n; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      tick();
    end
    chk("drain_q0_empty", q0.size(), 0);
    chk("drain_q1_empty", q1.size(), 0);
  endtask

  initial begin
    int n, acc, guard;
    bit seen;
    logic [7:0] t;

    tbl[0] = '{8'hF0, 8'hCC, 3'd0, 8'hC0, 1'b1, 1'b0};
    tbl[1] = '{8'hF0, 8'hCC, 3'd1, 8'hFC, 1'b1, 1'b0};
    tbl[2] = '{8'hF0, 8'hCC, 3'd2, 8'h3C, 1'b1, 1'b0};
    tbl[3] = '{8'hF0, 8'hCC, 3'd3, 8'h3F, 1'b1, 1'b0};
    tbl[4] = '{8'hF0, 8'hCC, 3'd4, 8'h03, 1'b1, 1'b0};
    tbl[5] = '{8'hF0, 8'hCC, 3'd5, 8'hC3, 1'b1, 1'b0};
    tbl[6] = '{8'hF0, 8'hCC, 3'd6, 8'h0F, 1'b1, 1'b0};
    tbl[7] = '{8'hF0, 8'hCC, 3'd7, 8'h00, 1'b0, 1'b1};

    // Reset state
    #12;
    chk("rst_ov", ov0, 0);
    chk("rst_y", y0, 0);
    chk("rst_any", any0, 0);
    chk("rst_err", err0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_ov1", ov1, 0);
    #1 rst_n = 1;
    @(posedge clk); #1;
    chk("rst_in_ready", ir0, 1);
    chk("rst_in_ready1", ir1, 1);

    // Ops, back to back, fixed latency
    lat_chk = 1;
    ordy0 = 1;
    for (int i = 0; i < 8; i++) begin
      drive0(tbl[i]);
      iv0 = 1;
      n = 0;
      do begin tick(); n++; end while (!hit0 && n < 20);
      chk("ops_one_per_cycle", n, 1);
    end
    drain(20);
    lat_chk = 0;
    chk("ops_cnt", cnt0, 8);

    // Backpressure: two held, third accepted as first leaves
    ordy0 = 0;
    drive0(tbl[0]); iv0 = 1; tick();
    chk("bp_acc0", hit0, 1);
    drive0(tbl[1]); tick();
    chk("bp_acc1", hit0, 1);
    drive0(tbl[2]); #1;
    chk("bp_full_ready", ir0, 0);
    chk("bp_full_valid", ov0, 1);
    chk("bp_hold_y", y0, 8'hC0);
    tick();
    chk("bp_not_acc", hit0, 0);
    chk("bp_hold_y2", y0, 8'hC0);
    ordy0 = 1; #1;
    chk("bp_ready_pass", ir0, 1);
    chk("bp_valid_pass", ov0, 1);
    tick();
    chk("bp_acc2", hit0, 1);
    drain(20);
    chk("bp_cnt", cnt0, 11);

    // Exhaustive 1-bit, single stage, 4-bit counter
    for (int pass = 0; pass < 2; pass++) begin
      for (int o = pass * 4; o < pass * 4 + 4; o++) begin
        for (int ab = 0; ab < 4; ab++) begin
          a1 = ab[1]; b1 = ab[0]; op1 = o[2:0];
          t = gate({7'd0, a1}, {7'd0, b1}, op1);
          nx_y1 = {7'd0, t[0]};
          iv1 = 1;
          n = 0;
          do begin tick(); n++; end while (!hit1 && n < 20);
          chk("u1_accept", hit1, 1);
        end
      end
      drain(10);
      chk("u1_cnt_wrap", cnt1, 0);
    end

    // Random flow, 1000 items
    rst_n = 0; #3; rst_n = 1;
    q0.delete(); q1.delete();
    @(posedge clk); #1;
    acc = 0; pops0 = 0; guard = 0;
    while (acc < 1000 && guard < 20000) begin
      iv0 = $urandom_range(0, 1);
      ordy0 = $urandom_range(0, 1);
      a0 = 8'($urandom); b0 = 8'($urandom);
      op0 = 3'($urandom_range(0, 7));
      nx_y0 = gate(a0, b0, op0);
      nx_any0 = |nx_y0;
      nx_err0 = (op0 == 3'd7);
      tick();
      if (hit0) acc++;
      guard++;
    end
    chk("rnd_accepted", acc, 1000);
    drain(20);
    chk("rnd_pops", pops0, 1000);
    chk("rnd_cnt", cnt0, 232);

    // Async reset with full pipe
    ordy0 = 0;
    drive0(tbl[3]); iv0 = 1; tick();
    drive0(tbl[4]); tick();
    iv0 = 0; #1;
    chk("r6_full", ov0, 1);
    #2 rst_n = 0;
    #1;
    chk("r6_ov_async", ov0, 0);
    chk("r6_cnt_async", cnt0, 0);
    chk("r6_y_async", y0, 0);
    q0.delete();
    @(posedge clk); #3 rst_n = 1;
    @(posedge clk); #1;
    chk("r6_in_ready", ir0, 1);
    ordy0 = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (ov0) seen = 1;
      tick();
    end
    chk("r6_no_stale", seen, 0);
    chk("r6_cnt", cnt0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
